vga_sync_receiver: RTL and testbench

- Sink-side counterpart of the VGA timing generator.
- Observes an Hsync/Vsync pair in the 25 MHz pixel domain, locks onto it, and regenerates column/row counters plus an active-video qualifier.
- Used to check timing and feed overlay logic that sits downstream of the sync/porch stage.
- Flags and counts timing violations; drops lock after repeated bad lines.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/sync_edge_detector.sv | 53 +++++
 rtl/vga_sync_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter width and receiver FSM
// state encoding for the VGA sync receiver and its helpers.
package vga_timing_pkg;

   // Width of the regenerated column/row counters.
   localparam int CNT_W = 10;

   // Horizontal timing, in pixel clocks.
   localparam int VGA_TOTAL_COLS    = 800;
   localparam int VGA_ACTIVE_COLS   = 640;
   localparam int VGA_H_FRONT_PORCH = 16;
   localparam int VGA_H_SYNC_WIDTH  = 96;
   localparam int VGA_H_BACK_PORCH  = 48;

   // Vertical timing, in lines.
   localparam int VGA_TOTAL_ROWS    = 525;
   localparam int VGA_ACTIVE_ROWS   = 480;
   localparam int VGA_V_FRONT_PORCH = 10;
   localparam int VGA_V_SYNC_WIDTH  = 2;
   localparam int VGA_V_BACK_PORCH  = 33;

   // Lock acquisition and loss thresholds.
   localparam int VGA_LOCK_LINES    = 4;
   localparam int VGA_MAX_ERRORS    = 3;

   // Receiver lock state machine.
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      H_TRAIN  = 2'd1,
      V_WAIT   = 2'd2,
      LOCKED   = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_edge_detector.sv
// Turns one raw sync input into a single-cycle pulse on its assertion.
// Optional two-flop input synchronizer under SYNC_INPUT_SYNCHRONIZER_EN
// (adds 2 cycles, for sync sources asynchronous to clock); polarity is
// normalised to active-high before the registered rising-edge detect.
module sync_edge_detector #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sync_in,
   output logic edge_pulse
);

   // Inactive level of the raw input, so reset never fakes an assertion.
   localparam logic IDLE_LEVEL = ACTIVE_LOW;

   logic sync_raw;
   logic sync_norm;
   logic sync_prev;

`ifdef SYNC_INPUT_SYNCHRONIZER_EN
   logic [1:0] sync_ff;

   // Two-flop synchronizer for an asynchronous sync source.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= {2{IDLE_LEVEL}};
      end else begin
         sync_ff <= {sync_ff[0], sync_in};
      end
   end

   assign sync_raw = sync_ff[1];
`else
   assign sync_raw = sync_in;
`endif

   assign sync_norm = ACTIVE_LOW ? ~sync_raw : sync_raw;

   // Registered 0->1 detect of the normalised sync.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_prev  <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_prev  <= sync_norm;
         edge_pulse <= sync_norm & ~sync_prev;
      end
   end

endmodule

// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing receiver: locks onto an Hsync/Vsync pair, regenerates
// column/row counters and active video, and flags/counts bad lines.
// Build option: SYNC_INPUT_SYNCHRONIZER_EN adds a two-flop synchronizer on
// each sync input (counters then lag raw sync by 2 extra cycles).
module vga_sync_receiver
   import vga_timing_pkg::*;
#(
   parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
   parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
   parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
   parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
   parameter int H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
   parameter int V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
   parameter int LOCK_LINES      = VGA_LOCK_LINES,
   parameter int MAX_ERRORS      = VGA_MAX_ERRORS,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_Hsync,
   input  logic             in_Vsync,
   output logic [CNT_W-1:0] column_count,
   output logic [CNT_W-1:0] row_count,
   output logic             active_video,
   output logic             frame_start,
   output logic             locked,
   output logic             sync_error,
   output logic [7:0]       error_count
);

   localparam int LEN_W  = $clog2(TOTAL_COLS + 2);
   localparam int GOOD_W = $clog2(LOCK_LINES + 1);
   localparam int ERRS_W = $clog2(MAX_ERRORS + 1);

   localparam logic [CNT_W-1:0]  COL_LAST    = CNT_W'(TOTAL_COLS - 1);
   localparam logic [CNT_W-1:0]  ROW_LAST    = CNT_W'(TOTAL_ROWS - 1);
   localparam logic [CNT_W-1:0]  COL_LOAD    = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
   localparam logic [CNT_W-1:0]  ROW_LOAD    = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
   localparam logic [CNT_W-1:0]  ROW_PRE_VS  = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH - 1);
   localparam logic [CNT_W-1:0]  COL_ACTIVE  = CNT_W'(ACTIVE_COLS);
   localparam logic [CNT_W-1:0]  ROW_ACTIVE  = CNT_W'(ACTIVE_ROWS);
   localparam logic [LEN_W-1:0]  LEN_ONE     = LEN_W'(1);
   localparam logic [LEN_W-1:0]  LEN_GOOD    = LEN_W'(TOTAL_COLS);
   localparam logic [LEN_W-1:0]  LEN_TIMEOUT = LEN_W'(TOTAL_COLS + 1);
   localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_LINES);
   localparam logic [ERRS_W-1:0] ERRS_LIMIT  = ERRS_W'(MAX_ERRORS);

   logic              h_edge;
   logic              v_edge;
   logic [CNT_W-1:0]  col_next;
   logic [CNT_W-1:0]  row_next;
   logic [LEN_W-1:0]  line_len;
   logic [LEN_W-1:0]  line_len_next;
   logic              line_timeout;
   logic              line_good;
   logic              line_bad;
   logic              vs_misplaced;
   rx_state_t         state;
   rx_state_t         state_next;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_next;
   logic [GOOD_W-1:0] good_inc;
   logic [ERRS_W-1:0] errs;
   logic [ERRS_W-1:0] errs_next;
   logic [ERRS_W-1:0] errs_inc;
   logic              err_pulse;
   logic              lock_next;

   sync_edge_detector #(
      .ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_hsync_edge (
      .clock      (clock),
      .reset_n    (reset_n),
      .sync_in    (in_Hsync),
      .edge_pulse (h_edge)
   );

   sync_edge_detector #(
      .ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_vsync_edge (
      .clock      (clock),
      .reset_n    (reset_n),
      .sync_in    (in_Vsync),
      .edge_pulse (v_edge)
   );

   // Line qualification: the edge cycle is cycle 1 of the next line, so a
   // correct line shows exactly TOTAL_COLS here; a missing Hsync is declared
   // one cycle later and restarts the measurement as if an edge had arrived.
   assign line_timeout  = !h_edge && (line_len == LEN_TIMEOUT);
   assign line_good     = h_edge && (line_len == LEN_GOOD);
   assign vs_misplaced  = v_edge && (state == LOCKED) && (row_count != ROW_PRE_VS);
   assign line_bad      = (h_edge && (line_len != LEN_GOOD)) || line_timeout || vs_misplaced;
   assign line_len_next = (h_edge || line_timeout) ? LEN_ONE : line_len + 1'b1;
   assign good_inc      = good_cnt + 1'b1;
   assign errs_inc      = errs + 1'b1;

   // Next column/row: sync edges load the porch-end positions, else free-run.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      col_next = column_count;
      row_next = row_count;
      if (h_edge) begin
         col_next = COL_LOAD;
      end else if (column_count == COL_LAST) begin
         col_next = '0;
         row_next = (row_count == ROW_LAST) ? '0 : row_count + 1'b1;
      end else begin
         col_next = column_count + 1'b1;
      end
      if (v_edge) begin
         row_next = ROW_LOAD;
      end
   end

   // Lock FSM next state: train on good lines, wait for Vsync, track errors.
   always_comb begin
      state_next = state;
      good_next  = good_cnt;
      errs_next  = errs;
      err_pulse  = 1'b0;
      case (state)
         UNLOCKED: begin
            if (h_edge) begin
               state_next = H_TRAIN;
               good_next  = '0;
               errs_next  = '0;
            end
         end
         H_TRAIN: begin
            if (line_bad) begin
               good_next = '0;
            end else if (line_good) begin
               good_next = good_inc;
               if (good_inc == GOOD_TARGET) begin
                  state_next = V_WAIT;
               end
            end
         end
         V_WAIT: begin
            if (line_bad) begin
               state_next = H_TRAIN;
               good_next  = '0;
            end else if (v_edge) begin
               state_next = LOCKED;
               errs_next  = '0;
            end
         end
         LOCKED: begin
            if (line_bad) begin
               err_pulse = 1'b1;
               errs_next = errs_inc;
               if (errs_inc == ERRS_LIMIT) begin
                  state_next = UNLOCKED;
                  errs_next  = '0;
               end
            end else if (line_good) begin
               errs_next = '0;
            end
         end
         default: begin
            state_next = UNLOCKED;
         end
      endcase
   end

   assign lock_next = (state_next == LOCKED);
   assign locked    = (state == LOCKED);

   // FSM state and training/error counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= UNLOCKED;
         good_cnt <= '0;
         errs     <= '0;
      end else begin
         state    <= state_next;
         good_cnt <= good_next;
         errs     <= errs_next;
      end
   end

   // Counters and registered outputs, qualifiers aligned with the counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         column_count <= '0;
         row_count    <= '0;
         line_len     <= '0;
         active_video <= 1'b0;
         frame_start  <= 1'b0;
         sync_error   <= 1'b0;
         error_count  <= '0;
      end else begin
         column_count <= col_next;
         row_count    <= row_next;
         line_len     <= line_len_next;
         active_video <= lock_next && (col_next < COL_ACTIVE) && (row_next < ROW_ACTIVE);
         frame_start  <= lock_next && (col_next == '0) && (row_next == '0);
         sync_error   <= err_pulse;
         if (err_pulse && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver (default build, low-active syncs).
// A raw 800x525 timing generator drives the syncs; line lengths, Hsync
// presence and extra Vsync lines are steered per scenario.
module tb_vga_sync_receiver;
   import vga_timing_pkg::*;

   localparam int H_SYNC_START = 656;
   localparam int V_SYNC_START = 490;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       in_Hsync;
   logic       in_Vsync;
   logic [9:0] column_count;
   logic [9:0] row_count;
   logic       active_video;
   logic       frame_start;
   logic       locked;
   logic       sync_error;
   logic [7:0] error_count;

   vga_sync_receiver dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_Hsync     (in_Hsync),
      .in_Vsync     (in_Vsync),
      .column_count (column_count),
      .row_count    (row_count),
      .active_video (active_video),
      .frame_start  (frame_start),
      .locked       (locked),
      .sync_error   (sync_error),
      .error_count  (error_count)
   );

   always #20 clock = ~clock;

   int   n_tests = 0;
   int   n_fail  = 0;

   // Raw generator position and scenario knobs.
   int   g_col = 0;
   int   g_row = 0;
   int   short_row = -1;
   int   long_lo = -1;
   int   long_hi = -1;
   int   extra_vs_row = -1;
   bit   hsync_en = 1'b1;

   // Observations accumulated at every sample point.
   int   cyc = 0;
   int   n_err = 0;
   int   n_fs = 0;
   int   n_av = 0;
   int   n_lock_hi = 0;
   int   cyc0 = 0;
   logic err_locked [8];
   int   err_cyc [8];

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      logic h_on;
      logic v_on;
      h_on = (g_col >= H_SYNC_START) && (g_col < H_SYNC_START + VGA_H_SYNC_WIDTH);
      v_on = ((g_row >= V_SYNC_START) && (g_row < V_SYNC_START + VGA_V_SYNC_WIDTH)) ||
             (g_row == extra_vs_row);
      in_Hsync = hsync_en ? ~h_on : 1'b1;
      in_Vsync = ~v_on;
   endtask

   // One pixel: advance the generator after the edge, sample on negedge.
   task automatic step();
      int last_col;
      @(posedge clock);
      #1;
      last_col = (g_row == short_row) ? 798 :
                 ((g_row >= long_lo) && (g_row <= long_hi)) ? 800 : 799;
      if (g_col >= last_col) begin
         g_col = 0;
         g_row = (g_row == 524) ? 0 : g_row + 1;
      end else begin
         g_col = g_col + 1;
      end
      drive();
      @(negedge clock);
      cyc++;
      if (sync_error) begin
         if (n_err < 8) begin
            err_locked[n_err] = locked;
            err_cyc[n_err]    = cyc;
         end
         n_err++;
      end
      if (frame_start)  n_fs++;
      if (active_video) n_av++;
      if (locked)       n_lock_hi++;
   endtask

   task automatic run_until(input int col, input int row, input int budget, input string tag);
      int n;
      n = 0;
      while (!((g_col == col) && (g_row == row)) && (n < budget)) begin
         step();
         n++;
      end
      check(tag, int'((g_col == col) && (g_row == row)), 1);
   endtask

   initial begin
      // Reset with toggling syncs: everything stays at zero.
      reset_n  = 1'b0;
      in_Hsync = 1'b1;
      in_Vsync = 1'b1;
      repeat (4) begin
         @(posedge clock);
         #1;
         in_Hsync = ~in_Hsync;
         in_Vsync = ~in_Vsync;
      end
      @(negedge clock);
      check("rst_column", column_count, 0);
      check("rst_row", row_count, 0);
      check("rst_active", active_video, 0);
      check("rst_frame", frame_start, 0);
      check("rst_locked", locked, 0);
      check("rst_sync_err", sync_error, 0);
      check("rst_err_cnt", error_count, 0);

      g_col = 0;
      g_row = 484;
      drive();
      @(negedge clock);
      reset_n = 1'b1;

      // Clean lock: 4 good lines from row 484, then Vsync at row 490.
      n_err = 0;
      n_lock_hi = 0;
      run_until(0, 490, 6000, "reach_vs1");
      check("prelock_locked_seen", n_lock_hi, 0);
      check("train_err_pulses", n_err, 0);
      step();
      check("lock_vs_edge_cycle", locked, 0);
      step();
      check("lock_rise", locked, 1);
      check("lock_column", column_count, 0);
      check("lock_row", row_count, 490);

      // Frame start at (0,0) and 640 active pixels on rows 0 and 1.
      n_fs = 0;
      n_av = 0;
      run_until(2, 0, 30000, "reach_row0");
      check("fs_pulse", frame_start, 1);
      check("fs_column", column_count, 0);
      check("fs_row", row_count, 0);
      check("av_at_origin", active_video, 1);
      repeat (799) step();
      check("av_row0_count", n_av, 640);
      check("av_col799", active_video, 0);
      check("col_last", column_count, 799);
      repeat (800) step();
      check("av_row1_count", n_av, 1280);
      check("fs_once", n_fs, 1);

      // Short line while locked: one error, lock kept.
      short_row = 2;
      n_err = 0;
      run_until(700, 3, 2000, "reach_short");
      short_row = -1;
      check("short_err_pulses", n_err, 1);
      check("short_err_cnt", error_count, 1);
      check("short_locked", locked, 1);
      run_until(700, 4, 1000, "reach_good_after_short");

      // Three 801-cycle lines: lock drops with the third error.
      long_lo = 4;
      long_hi = 6;
      n_err = 0;
      run_until(700, 7, 3000, "reach_long");
      long_lo = -1;
      long_hi = -1;
      check("loss_err_pulses", n_err, 3);
      check("loss_locked_p1", err_locked[0], 1);
      check("loss_locked_p2", err_locked[1], 1);
      check("loss_locked_p3", err_locked[2], 0);
      check("loss_err_cnt", error_count, 4);
      check("loss_locked", locked, 0);

      // Re-lock: skip ahead to row 484 and retrain up to the row-490 Vsync.
      g_row = 484;
      drive();
      n_err = 0;
      run_until(1, 490, 6000, "reach_vs2");
      check("relock_pre", locked, 0);
      step();
      check("relock_rise", locked, 1);
      check("relock_row", row_count, 490);
      check("relock_column", column_count, 0);
      check("relock_err_pulses", n_err, 0);

      // Missing Hsync: an error every 801 cycles, lock lost on the third.
      hsync_en = 1'b0;
      drive();
      n_err = 0;
      cyc0 = cyc;
      repeat (2400) step();
      check("miss_err_pulses", n_err, 3);
      check("miss_first_delay", err_cyc[0] - cyc0, 657);
      check("miss_gap1", err_cyc[1] - err_cyc[0], 801);
      check("miss_gap2", err_cyc[2] - err_cyc[1], 801);
      check("miss_locked_p2", err_locked[1], 1);
      check("miss_locked_p3", err_locked[2], 0);
      check("miss_err_cnt", error_count, 7);

      // Training restart: 3 good, 1 bad, 4 good; an early Vsync must not lock.
      run_until(0, 494, 1000, "reach_restart");
      g_row = 481;
      hsync_en = 1'b1;
      long_lo = 484;
      long_hi = 484;
      extra_vs_row = 487;
      drive();
      n_err = 0;
      run_until(10, 487, 5000, "reach_early_vs");
      check("restart_no_early_lock", locked, 0);
      run_until(1, 490, 3000, "reach_vs3");
      check("restart_pre", locked, 0);
      step();
      check("restart_lock", locked, 1);
      check("restart_err_pulses", n_err, 0);
      check("restart_err_cnt", error_count, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
